// File: rtl/clock_divider_multi_pkg.sv
// Shared types and defaults for the multi-channel clock divider.
package clock_divider_pkg;

  localparam int DEF_DIV_DFLT = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    BYPASS = 2'd2
  } ch_state_e;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_divider_multi_if.sv
// Divisor-write bus: valid/ready handshake carrying channel and divisor.
interface clock_divider_multi_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 16
);
  localparam int CHW = clock_divider_pkg::ch_w(NCH);

  logic             cfg_valid;
  logic [CHW-1:0]   cfg_ch;
  logic [WIDTH-1:0] cfg_div;
  logic             cfg_ready;

  modport master (output cfg_valid, cfg_ch, cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, output cfg_ready);
endinterface

// File: rtl/clock_divider_multi_channel.sv
// One divider channel: active/pending divisor, period counter, IDLE/RUN/BYPASS FSM
// and falling-edge bypass gate so clk_in can be passed through without glitches.
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEF_DIV = DEF_DIV_DFLT
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_div,
  output logic             o_pend,
  output logic             o_clk,
  output logic             o_tick
);

  ch_state_e        r_state, w_state_nxt;
  logic [WIDTH-1:0] r_d, w_d_nxt;
  logic [WIDTH-1:0] r_p, w_p_nxt;
  logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic             r_pend, w_pend_nxt;
  logic             r_out, w_out_nxt;
  logic             r_byp;

  logic [WIDTH-1:0] w_last, w_eff, w_cnt_inc, w_hi_len;
  logic             w_at_last, w_bound;

  assign w_last    = r_d - WIDTH'(1);
  assign w_at_last = (r_cnt == w_last);
  assign w_eff     = r_pend ? r_p : r_d;
  assign w_cnt_inc = r_cnt + WIDTH'(1);
  assign w_hi_len  = r_d - (r_d >> 1);
  // IDLE and BYPASS are one-cycle periods, so every edge is a boundary there.
  assign w_bound   = (r_state != RUN) || w_at_last;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_d     <= WIDTH'(DEF_DIV);
      r_p     <= '0;
      r_pend  <= 1'b0;
      r_cnt   <= '0;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_d     <= w_d_nxt;
      r_p     <= w_p_nxt;
      r_pend  <= w_pend_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_d_nxt     = r_d;
    w_p_nxt     = r_p;
    w_pend_nxt  = r_pend;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;

    if (w_bound && r_pend) begin
      w_d_nxt    = r_p;
      w_pend_nxt = 1'b0;
    end
    // Writes are only offered while nothing is pending, so this never races the copy above.
    if (i_wr && !r_pend) begin
      w_p_nxt    = i_div;
      w_pend_nxt = 1'b1;
    end

    case (r_state)
      IDLE, BYPASS: begin
        w_cnt_nxt = '0;
        w_out_nxt = 1'b0;
        if (!i_en) begin
          w_state_nxt = IDLE;
        end else if (w_eff > WIDTH'(1)) begin
          w_state_nxt = RUN;
          w_out_nxt   = 1'b1;
        end else begin
          w_state_nxt = BYPASS;
        end
      end
      RUN: begin
        if (w_at_last) begin
          w_cnt_nxt = '0;
          if (!i_en) begin
            w_state_nxt = IDLE;
            w_out_nxt   = 1'b0;
          end else if (w_eff < WIDTH'(2)) begin
            w_state_nxt = BYPASS;
            w_out_nxt   = 1'b0;
          end else begin
            w_out_nxt   = 1'b1;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
          w_out_nxt = (w_cnt_inc < w_hi_len);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_out_nxt   = 1'b0;
      end
    endcase
  end

  // Sampled while clk_in is low so the AND gate below only opens/closes in the low phase.
  always_ff @(negedge clk_in or posedge rst) begin
    if (rst) r_byp <= 1'b0;
    else     r_byp <= (r_state == BYPASS);
  end

  assign o_clk  = r_out | (clk_in & r_byp);
  assign o_tick = (r_state == RUN) && w_at_last;
  assign o_pend = r_pend;

endmodule

// File: rtl/clock_divider_multi.sv
// NCH independent clock dividers sharing one divisor-write port.
module clock_divider_multi
  import clock_divider_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int WIDTH   = 16,
  parameter int DEF_DIV = DEF_DIV_DFLT
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic [NCH-1:0]        en,
  clock_divider_multi_if.slave  cfg,
  output logic [NCH-1:0]        clk_out,
  output logic [NCH-1:0]        tick
);

  localparam int CHW = ch_w(NCH);

  logic [NCH-1:0] w_pend;
  logic [NCH-1:0] w_wr;

  // Out-of-range selects match no channel and leave ready low.
  always_comb begin
    cfg.cfg_ready = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (cfg.cfg_ch == CHW'(c)) cfg.cfg_ready = ~w_pend[c];
    end
  end

  always_comb begin
    w_wr = '0;
    for (int c = 0; c < NCH; c++) begin
      w_wr[c] = cfg.cfg_valid && cfg.cfg_ready && (cfg.cfg_ch == CHW'(c));
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clock_divider_channel #(
      .WIDTH   (WIDTH),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk_in (clk_in),
      .rst    (rst),
      .i_en   (en[g]),
      .i_wr   (w_wr[g]),
      .i_div  (cfg.cfg_div),
      .o_pend (w_pend[g]),
      .o_clk  (clk_out[g]),
      .o_tick (tick[g])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Scoreboard bench: a period-level reference model predicts each cycle's outputs.
module tb_clock_divider_multi;

  localparam int NCH   = 3;
  localparam int WIDTH = 16;
  localparam int CHW   = 2;

  logic           clk_in = 1'b0;
  logic           rst;
  logic [NCH-1:0] en;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] tick;

  clock_divider_multi_if #(.NCH(NCH), .WIDTH(WIDTH)) cif ();

  clock_divider_multi #(.NCH(NCH), .WIDTH(WIDTH), .DEF_DIV(2)) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .en      (en),
    .cfg     (cif.slave),
    .clk_out (clk_out),
    .tick    (tick)
  );

  always #5 clk_in = ~clk_in;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [NCH-1:0] hi;
    logic [NCH-1:0] lo;
    logic [NCH-1:0] tk;
  } smp_t;

  smp_t sb[$];
  logic rq[$];

  // Reference model: each period is described by kind (0 idle, 1 run, 2 bypass),
  // its length in cycles and the position inside it.
  int m_D[NCH], m_P[NCH], m_kind[NCH], m_len[NCH], m_pos[NCH];
  bit m_pend[NCH], m_prevbyp[NCH];

  task automatic chk(input string nm, input logic [NCH-1:0] act, input logic [NCH-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : model
    forever begin
      bit   wr_ok;
      int   wch;
      smp_t s;
      @(posedge clk_in);
      if (rst) begin
        for (int c = 0; c < NCH; c++) begin
          m_D[c] = 2; m_P[c] = 0; m_pend[c] = 0;
          m_kind[c] = 0; m_len[c] = 1; m_pos[c] = 0; m_prevbyp[c] = 0;
        end
        sb.delete();
      end else begin
        wch   = int'(cif.cfg_ch);
        wr_ok = cif.cfg_valid && (wch < NCH) && !m_pend[wch];
        for (int c = 0; c < NCH; c++) begin
          if (m_pos[c] == m_len[c] - 1) begin
            if (m_pend[c]) begin m_D[c] = m_P[c]; m_pend[c] = 0; end
            m_pos[c] = 0;
            if (!en[c])          begin m_kind[c] = 0; m_len[c] = 1;      end
            else if (m_D[c] >= 2) begin m_kind[c] = 1; m_len[c] = m_D[c]; end
            else                 begin m_kind[c] = 2; m_len[c] = 1;      end
          end else begin
            m_pos[c]++;
          end
          s.lo[c] = (m_kind[c] == 1) && (m_pos[c] < m_len[c] - m_len[c] / 2);
          s.tk[c] = (m_kind[c] == 1) && (m_pos[c] == m_len[c] - 1);
          s.hi[c] = s.lo[c] | m_prevbyp[c];
          m_prevbyp[c] = (m_kind[c] == 2);
        end
        if (wr_ok) begin m_pend[wch] = 1; m_P[wch] = int'(cif.cfg_div); end
        sb.push_back(s);
      end
    end
  end

  initial begin : monitor
    forever begin
      smp_t cur;
      bit   have;
      have = 0;
      @(posedge clk_in); #1;
      if (rst) begin
        chk("rst_clk_hi", clk_out, '0);
        chk("rst_tick", tick, '0);
      end else if (sb.size() > 0) begin
        cur  = sb.pop_front();
        have = 1;
        chk("clk_out_hi", clk_out, cur.hi);
        chk("tick_hi", tick, cur.tk);
      end
      @(negedge clk_in); #1;
      if (rst) begin
        chk("rst_clk_lo", clk_out, '0);
      end else if (have) begin
        chk("clk_out_lo", clk_out, cur.lo);
        chk("tick_lo", tick, cur.tk);
      end
      if (rq.size() > 0) chk("cfg_ready", {{(NCH-1){1'b0}}, cif.cfg_ready}, {{(NCH-1){1'b0}}, rq.pop_front()});
    end
  end

  task automatic drv(input logic [NCH-1:0] e, input logic v, input int ch, input int div);
    logic [31:0] chv;
    logic [31:0] dv;
    chv = ch;
    dv  = div;
    en            = e;
    cif.cfg_valid = v;
    cif.cfg_ch    = chv[CHW-1:0];
    cif.cfg_div   = dv[WIDTH-1:0];
    if (ch < NCH) rq.push_back(rst || !m_pend[ch]);
    else          rq.push_back(1'b0);
  endtask

  task automatic cyc(input logic [NCH-1:0] e, input logic v, input int ch, input int div);
    @(negedge clk_in);
    drv(e, v, ch, div);
  endtask

  // Returns at the negedge where channel c is in RUN at the requested position.
  task automatic sync_to(input int c, input int len, input int pos, input logic [NCH-1:0] e);
    bit hit;
    hit = 0;
    for (int k = 0; k < 60 && !hit; k++) begin
      @(negedge clk_in);
      if (m_kind[c] == 1 && m_len[c] == len && m_pos[c] == pos) hit = 1;
      else drv(e, 1'b0, 0, 0);
    end
    n_chk++;
    if (!hit) begin
      n_fail++;
      $display("FAIL sync_to ch%0d: got no match, expected len %0d pos %0d", c, len, pos);
    end
  endtask

  initial begin : stim
    logic [NCH-1:0] e;
    rst = 1'b1;
    en  = '0;
    cif.cfg_valid = 1'b0;
    cif.cfg_ch    = '0;
    cif.cfg_div   = '0;

    repeat (3) cyc('0, 1'b0, 0, 0);
    cyc('0, 1'b0, 1, 0);
    cyc('0, 1'b0, 2, 0);
    cyc('0, 1'b0, 3, 0);
    @(negedge clk_in); rst = 1'b0; drv('0, 1'b0, 0, 0);

    // ch0 at the reset divisor of 2
    repeat (10) cyc(3'b001, 1'b0, 0, 0);

    // ch1 at 5: 3 high, 2 low
    cyc(3'b001, 1'b1, 1, 5);
    repeat (16) cyc(3'b011, 1'b0, 0, 0);

    // ch2 at 4, then retarget to 8 at cnt=1; a second write and a bad select must bounce
    cyc(3'b011, 1'b1, 2, 4);
    repeat (6) cyc(3'b111, 1'b0, 0, 0);
    sync_to(2, 4, 1, 3'b111);
    drv(3'b111, 1'b1, 2, 8);
    cyc(3'b111, 1'b1, 2, 3);
    cyc(3'b111, 1'b1, 3, 7);
    repeat (20) cyc(3'b111, 1'b0, 0, 0);

    // ch2 back to 4, then divisor 1 puts it into bypass
    cyc(3'b111, 1'b1, 2, 4);
    repeat (12) cyc(3'b111, 1'b0, 0, 0);
    cyc(3'b111, 1'b1, 2, 1);
    repeat (14) cyc(3'b111, 1'b0, 0, 0);

    // ch0 at 6, en dropped at cnt=0
    cyc(3'b111, 1'b1, 0, 6);
    sync_to(0, 6, 0, 3'b111);
    drv(3'b110, 1'b0, 0, 0);
    repeat (12) cyc(3'b110, 1'b0, 0, 0);

    // random traffic
    e = 3'b110;
    repeat (1500) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 15) == 0) e[c] = ~e[c];
      if ($urandom_range(0, 2) == 0)
        cyc(e, 1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 9)));
      else
        cyc(e, 1'b0, 0, 0);
    end

    // reset in the middle of a high phase
    repeat (6) cyc(3'b111, 1'b0, 0, 0);
    @(posedge clk_in); #3;
    rst = 1'b1;
    #1;
    chk("rst_async_clk", clk_out, '0);
    chk("rst_async_tick", tick, '0);
    repeat (3) cyc(3'b111, 1'b0, 0, 0);
    @(negedge clk_in); rst = 1'b0; drv(3'b001, 1'b0, 0, 0);
    repeat (10) cyc(3'b001, 1'b0, 0, 0);
    repeat (2) @(negedge clk_in);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_divider_multi.md
CLOCK_DIVIDER_MULTI -- requirements
Module: clock_divider_multi

Interface
REQ-001 Parameter NCH, default 4: number of independent divider channels (1..16).
REQ-002 Parameter WIDTH, default 16: divisor width in bits.
REQ-003 Parameter DEF_DIV, default 2: divisor loaded into every channel at reset.
REQ-004 Port clk_in  input  1: the single clock; reset is asynchronous and active-high.
REQ-005 Port rst  input  1: asynchronous, active-high reset.
REQ-006 Port en  input  NCH: per-channel run enable, level-sensitive.
REQ-007 Port cfg_valid  input  1: divisor write request.
REQ-008 Port cfg_ch  input  clog2(NCH) (minimum 1): target channel of a write.
REQ-009 Port cfg_div  input  WIDTH: new divisor value.
REQ-010 Port cfg_ready  output  1: write accepted when cfg_valid and cfg_ready are both high at a clk_in rising edge.
REQ-011 Port clk_out  output  NCH: divided clocks.
REQ-012 Port tick  output  NCH: one-cycle pulse on the last clk_in cycle of each output period.

Function
REQ-013 Each channel SHALL hold an active divisor D, a pending divisor P with a pending flag, a counter cnt of width WIDTH, and a state from IDLE, RUN, BYPASS.
REQ-014 cfg_ready SHALL be combinational: high iff the pending flag of channel cfg_ch is clear; cfg_ch >= NCH SHALL force cfg_ready low.
REQ-015 An accepted write SHALL store cfg_div into P and set the pending flag; it SHALL NOT change D directly.
REQ-016 P SHALL be copied to D, and the flag cleared, only at a period boundary: in IDLE on any edge, in RUN when cnt == D-1, and in BYPASS on any edge.
REQ-017 In RUN, cnt SHALL count 0..D-1 and wrap; out_q SHALL be high for cnt < D - floor(D/2) and low otherwise, so odd D gives the extra cycle high.
REQ-018 tick SHALL be high exactly when the state is RUN and cnt == D-1; tick SHALL be 0 in IDLE and BYPASS.
REQ-019 IDLE -> RUN when en is high and the effective D (after REQ-016) >= 2, with cnt = 0 and out_q = 1 on the first RUN cycle.
REQ-020 IDLE -> BYPASS when en is high and the effective D is 0 or 1.
REQ-021 RUN SHALL evaluate en and the new D only at cnt == D-1: en low -> IDLE; D < 2 -> BYPASS; otherwise restart at cnt 0.
REQ-022 Deasserting en mid-period SHALL complete the current period in full; no truncated high or low phase is permitted.
REQ-023 BYPASS -> IDLE when en is low; BYPASS -> RUN when the new D >= 2; both transitions SHALL occur at a rising edge.
REQ-024 clk_out[c] SHALL equal out_q[c] | (clk_in & byp_q[c]). byp_q[c] is set from (state == BYPASS) on the falling edge of clk_in, giving glitch-free gating.
REQ-025 Writes to different channels in consecutive cycles SHALL each be accepted; channels SHALL be fully independent.

Reset
REQ-026 While rst is high: state = IDLE, D = DEF_DIV, pending flag clear, cnt = 0, out_q = 0, byp_q = 0.
REQ-027 Under reset, clk_out = 0, tick = 0 and cfg_ready = 1 for every valid cfg_ch.
REQ-028 Reset asserted mid-operation SHALL force the REQ-026 values immediately, asynchronously, discarding any pending divisor.

Structure
REQ-029 A shared package clock_divider_pkg SHALL hold the channel state enum (IDLE, RUN, BYPASS) and the DEF_DIV default constant.
REQ-030 The per-channel logic SHALL be the sub-module clock_divider_channel, instantiated NCH times by generate.
REQ-031 The top level SHALL contain only the cfg decode, the cfg_ready mux and the output concatenation.

Verification
REQ-032 Reset, then en[0]=1 with DEF_DIV=2 -> clk_out[0] toggles every clk_in cycle, high on the first RUN cycle; tick[0] is high every 2nd cycle.
REQ-033 Write ch1 D=5, then en[1]=1 -> clk_out[1] is 3 cycles high, 2 low; tick[1] pulses every 5 cycles.
REQ-034 Write D=8 to a running D=4 channel at cnt=1 -> the current 4-cycle period completes, the next period is 8 cycles, and cfg_ready returns high at the boundary.
REQ-035 Second write to the same channel while its pending flag is set -> cfg_ready = 0 and the write is not taken; cfg_ch = NCH -> cfg_ready = 0.
REQ-036 Write D=1 to a running D=4 channel -> BYPASS after the period ends; clk_out follows clk_in from the next falling edge, with no pulse shorter than half a clk_in period.
REQ-037 en drops at cnt=0 of D=6 -> 6-cycle period completes, then clk_out = 0; rst asserted mid-period -> clk_out, tick = 0 asynchronously.
